// File: rtl/alu_mdu_if.sv
// Base-op encoding shared by the ALU/MDU and its clients, plus the
// request/response bundle between the execute stage and the ALU/MDU.
package alu_mdu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } t_aluop;
endpackage

interface alu_mdu_if #(
   parameter int WIDTH = 32
);
   import alu_mdu_pkg::*;

   logic             i_valid;
   logic             o_ready;
   logic             i_m_ext;
   t_aluop           i_funct;
   logic [2:0]       i_m_funct;
   logic [WIDTH-1:0] i_op_a;
   logic [WIDTH-1:0] i_op_b;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic             o_busy;

   // ALU/MDU side
   modport slave (
      input  i_valid, i_m_ext, i_funct, i_m_funct, i_op_a, i_op_b, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_busy
   );

   // execute-stage side
   modport master (
      output i_valid, i_m_ext, i_funct, i_m_funct, i_op_a, i_op_b, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_busy
   );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle ALU with RV32M multiply/divide. Base ops, multiplies and
// divide corner cases finish at the accept edge; regular divides run a
// restoring radix-2 loop on operand magnitudes, one quotient bit per cycle.
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic      i_clk,
   input  logic      i_rst_n,
   alu_mdu_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] op_a, op_b;
   logic [2:0]       mf;
   logic             ready, accept;

   logic             is_div, div_signed, b_zero, div_ovf, div_slow;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic               mul_a_sx, mul_b_sx;
   logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   fast_res;

   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] div_rem, div_quo, div_dvs;
   logic [CNT_W-1:0] div_cnt;
   logic             div_neg_q, div_neg_r, div_sel_rem;
   logic             div_last;

   logic [WIDTH:0]   div_shifted, div_diff;
   logic             div_qbit;
   logic [WIDTH-1:0] quo_fix, rem_fix, div_res;

   assign op_a  = bus.i_op_a;
   assign op_b  = bus.i_op_b;
   assign mf    = bus.i_m_funct;
   assign shamt = op_b[SHAMT_W-1:0];

   // handshake and status outputs
   always_comb begin
      ready  = (state == IDLE) || (state == DONE && bus.i_ready && !bus.i_flush);
      accept = bus.i_valid && ready && !bus.i_flush;
   end

   assign bus.o_ready  = ready;
   assign bus.o_valid  = (state == DONE);
   assign bus.o_busy   = (state == DIV);
   assign bus.o_result = result_q;

   // classify the incoming request and take divide operand magnitudes
   always_comb begin
      is_div     = bus.i_m_ext && mf[2];
      div_signed = !mf[0];
      b_zero     = (op_b == '0);
      div_ovf    = div_signed && (op_a == MOST_NEG) && (op_b == '1);
      div_slow   = is_div && !b_zero && !div_ovf;
      a_neg      = div_signed && op_a[WIDTH-1];
      b_neg      = div_signed && op_b[WIDTH-1];
      a_mag      = a_neg ? (~op_a + 1'b1) : op_a;
      b_mag      = b_neg ? (~op_b + 1'b1) : op_b;
   end

   // one 2*WIDTH product serves all four multiplies via operand extension
   always_comb begin
      mul_a_sx = (mf[1:0] != 2'b11);
      mul_b_sx = !mf[1];
      mul_a    = {{WIDTH{mul_a_sx && op_a[WIDTH-1]}}, op_a};
      mul_b    = {{WIDTH{mul_b_sx && op_b[WIDTH-1]}}, op_b};
      mul_p    = mul_a * mul_b;
   end

   // single-cycle result: base ops, multiplies, divide-by-zero and overflow
   always_comb begin
      fast_res = '0;
      if (!bus.i_m_ext) begin
         case (bus.i_funct)
            ALU_ADD:  fast_res = op_a + op_b;
            ALU_SUB:  fast_res = op_a - op_b;
            ALU_SLL:  fast_res = op_a << shamt;
            ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  fast_res = op_a ^ op_b;
            ALU_SRL:  fast_res = op_a >> shamt;
            ALU_SRA:  fast_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   fast_res = op_a | op_b;
            ALU_AND:  fast_res = op_a & op_b;
            default:  fast_res = '0;
         endcase
      end else if (!mf[2]) begin
         fast_res = (mf[1:0] == 2'b00) ? mul_p[WIDTH-1:0] : mul_p[2*WIDTH-1:WIDTH];
      end else if (b_zero) begin
         fast_res = mf[1] ? op_a : '1;
      end else begin
         // only signed overflow reaches here as a captured result
         fast_res = mf[1] ? '0 : op_a;
      end
   end

   // one restoring step and the final sign fix-up
   always_comb begin
      div_last    = (div_cnt == CNT_W'(WIDTH));
      div_shifted = {div_rem, div_quo[WIDTH-1]};
      div_diff    = div_shifted - {1'b0, div_dvs};
      div_qbit    = !div_diff[WIDTH];
      quo_fix     = div_neg_q ? (~div_quo + 1'b1) : div_quo;
      rem_fix     = div_neg_r ? (~div_rem + 1'b1) : div_rem;
      div_res     = div_sel_rem ? rem_fix : quo_fix;
   end

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state: flush wins, an accept restarts from either IDLE or DONE
   always_comb begin
      state_nxt = state;
      if (bus.i_flush) begin
         state_nxt = IDLE;
      end else if (accept) begin
         state_nxt = div_slow ? DIV : DONE;
      end else begin
         case (state)
            DIV:     if (div_last) state_nxt = DONE;
            DONE:    if (bus.i_ready) state_nxt = IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   // result register and divider datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         result_q    <= '0;
         div_rem     <= '0;
         div_quo     <= '0;
         div_dvs     <= '0;
         div_cnt     <= '0;
         div_neg_q   <= 1'b0;
         div_neg_r   <= 1'b0;
         div_sel_rem <= 1'b0;
      end else if (accept) begin
         if (div_slow) begin
            div_rem     <= '0;
            div_quo     <= a_mag;
            div_dvs     <= b_mag;
            div_cnt     <= '0;
            div_neg_q   <= a_neg ^ b_neg;
            div_neg_r   <= a_neg;
            div_sel_rem <= mf[1];
         end else begin
            result_q <= fast_res;
         end
      end else if (state == DIV && !bus.i_flush) begin
         if (div_last) begin
            result_q <= div_res;
         end else begin
            // dividend bits shift out of div_quo as quotient bits shift in
            div_rem <= div_qbit ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
            div_quo <= {div_quo[WIDTH-2:0], div_qbit};
            div_cnt <= div_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle ALU.
- Executes the base integer ops (t_aluop) plus the RV32M multiply/divide ops (funct3 encoding) on WIDTH-bit operands.
- Uses a valid/ready handshake on both sides, so the execute stage can stall on iterative division.
- Sits in the execute stage of each core, between operand forwarding and writeback.

Parameters:
- WIDTH, DATA_SIZE, operand/result width in bits; must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), number of low bits of i_op_b used as the shift amount.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request this cycle
- i_m_ext  in  1  1 = M-extension op (use i_m_funct); 0 = base op (use i_funct)
- i_funct  in  t_aluop  base op: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
- i_m_funct  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_op_a  in  WIDTH  operand A (rs1)
- i_op_b  in  WIDTH  operand B (rs2/imm)
- i_flush  in  1  synchronous abort of the in-flight op
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_result  out  WIDTH  result
- o_busy  out  1  divide iteration in progress

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_valid=0, o_result=0, o_busy=0, o_ready=1; divider registers cleared.
- FSM states: IDLE, DIV, DONE.
- Accept: a request is taken when i_valid && o_ready. Operands and op are captured at that edge; inputs are don't-care afterwards.
- o_ready = (state==IDLE) || (state==DONE && i_ready && !i_flush). Back-to-back issue is allowed in the cycle a result is consumed.
- Base ops and MUL* (single-cycle class): result registered at the accept edge; state goes to DONE; o_valid=1 the next cycle (latency 1).
- Shifts use only i_op_b[SHAMT_W-1:0]. SRA is arithmetic.
- SLT is signed, SLTU unsigned; result zero-extended 0/1.
- MUL returns the low WIDTH bits of the 2*WIDTH product.
- MULH returns the high half, signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
- DIV/DIVU/REM/REMU, normal case: state goes to DIV, o_busy=1.
  - Restoring radix-2 division on magnitudes, one quotient bit per cycle, WIDTH iterations.
  - Then sign fix-up and result registered; state DONE.
  - o_valid rises exactly WIDTH+1 cycles after the accept edge.
- Divide-by-zero (op_b==0), resolved in 1 cycle with no DIV state:
  - quotient = all ones (both signednesses);
  - remainder = op_a.
- Signed overflow (DIV/REM with op_a = most-negative, op_b = -1), 1 cycle: quotient = op_a; remainder = 0.
- Signs for signed ops: remainder takes the sign of the dividend; quotient truncates toward zero.
- DONE: o_valid=1 and o_result held stable until i_ready.
  - On i_ready without a new accept: go to IDLE, o_valid=0 next cycle.
  - On i_ready with a new accept: handle the new op as from IDLE.
- i_flush: highest priority after reset.
  - Any state goes to IDLE next cycle; o_valid=0, o_busy=0.
  - A request presented in the same cycle is not accepted (o_ready=0 when i_flush in DONE; in IDLE i_flush blocks acceptance).
- i_valid while in DIV: ignored. o_ready=0, so no capture.
- o_result is not cleared on leaving DONE; only o_valid qualifies it.

Test Plan:
- Base ops, WIDTH=32: ADD 0x7FFFFFFF+1 -> 0x80000000; SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1. Each with o_valid one cycle after accept, i_ready=1 back-to-back, one result per cycle.
- Multiply: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU -1 * 2 -> 0xFFFFFFFF; MUL 0x10000 * 0x10000 -> 0.
- Divide: DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each with o_valid exactly 33 cycles after accept and o_busy high during iteration. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corners: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. All with 1-cycle latency.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_result and o_valid stable, o_ready=0, i_valid ignored. Release -> next op accepted in the same cycle.
- Flush/reset: assert i_flush 10 cycles into a DIV -> IDLE and o_valid=0 next cycle, then a new ADD completes correctly. Pull i_rst_n low mid-DIV -> all outputs at reset values immediately.
